// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo: per-destination packet FIFO of the 1x3 router.
// 16 x 9-bit storage ({lfd, data}), 5-bit wrap pointers, registered read
// data, and a packet byte counter that returns data_out to its idle value
// once a packet has been fully delivered.
// Optional feature macro: ROUTER_FIFO_TRISTATE_EN (idle value 8'bz instead
// of 8'h00, for a shared output bus).
module router_pkt_fifo #(
  parameter int unsigned FIFO_WIDTH = 9,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       soft_reset,
  input  logic       write_enb,
  input  logic       read_enb,
  input  logic       lfd_state,
  input  logic [7:0] data_in,
  input  logic [1:0] addr,
  input  logic [5:0] payload_len,
  output logic [7:0] data_out,
  output logic       empty,
  output logic       full
);

  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned CNT_W  = 7;

`ifdef ROUTER_FIFO_TRISTATE_EN
  localparam logic [7:0] IDLE_VAL = 8'bzzzz_zzzz;
`else
  localparam logic [7:0] IDLE_VAL = 8'h00;
`endif

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [FIFO_WIDTH-1:0] rd_word;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  unused_inputs;

  // Destination tag and length are carried for visibility only.
  assign unused_inputs = ^{addr, payload_len};

  // Occupancy flags straight from the pointers; the wrap bit separates full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign wr_fire = write_enb && !full;
  assign rd_fire = read_enb && !empty;
  assign rd_word = mem[rd_ptr[ADDR_W-1:0]];

  // Storage write; contents are not cleared by either reset.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
    end
  end

  // Read and write pointers, modulo 2*depth.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (soft_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_fire) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Registered read data and remaining-bytes counter; header reload covers payload plus parity.
  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      data_out <= 8'h00;
    end else if (soft_reset) begin
      count    <= '0;
      data_out <= IDLE_VAL;
    end else if (rd_fire) begin
      data_out <= rd_word[7:0];
      if (rd_word[FIFO_WIDTH-1]) begin
        count <= CNT_W'(rd_word[7:2]) + CNT_W'(1);
      end else if (count != '0) begin
        count <= count - CNT_W'(1);
      end
    end else if (count == '0) begin
      data_out <= IDLE_VAL;
    end
  end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Scoreboard bench for router_pkt_fifo: stored bytes are queued at write
// time, and a monitor pops and compares one entry per accepted read.
module tb_router_pkt_fifo;

  logic       clock;
  logic       reset;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [1:0] addr;
  logic [5:0] payload_len;
  logic [7:0] data_out;
  logic       empty;
  logic       full;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic       mon_fire = 1'b0;
  logic [7:0] parity;

  logic [7:0] pay_a [10] = '{8'hA1, 8'h5C, 8'h37, 8'hE4, 8'h0B, 8'h9F, 8'h62, 8'hD8, 8'h13, 8'h7E};
  logic [7:0] pay_b [10] = '{8'h3A, 8'hC5, 8'h71, 8'h4E, 8'hB0, 8'hF9, 8'h26, 8'h8D, 8'h31, 8'hE7};

  router_pkt_fifo dut (
    .clock       (clock),
    .reset       (reset),
    .soft_reset  (soft_reset),
    .write_enb   (write_enb),
    .read_enb    (read_enb),
    .lfd_state   (lfd_state),
    .data_in     (data_in),
    .addr        (addr),
    .payload_len (payload_len),
    .data_out    (data_out),
    .empty       (empty),
    .full        (full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One write cycle; queue the byte if it is expected to be stored.
  task automatic wr(input logic [7:0] b, input logic lfd, input logic store);
    write_enb = 1'b1;
    data_in   = b;
    lfd_state = lfd;
    if (store) exp_q.push_back(b);
    @(negedge clock);
    lfd_state = 1'b0;
  endtask

  // Note accepted reads at the clock edge.
  always @(posedge clock) begin
    mon_fire <= read_enb && !empty && !reset && !soft_reset;
  end

  // Compare data_out for every accepted read against the scoreboard.
  always @(negedge clock) begin
    if (mon_fire) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_read: got %h expected no read", data_out);
      end else begin
        exp_b = exp_q.pop_front();
        chk("read_data", data_out, exp_b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    lfd_state = 1'b0; data_in = 8'h00; addr = 2'b00; payload_len = 6'd0;
    @(negedge clock);
    chk("rst_empty", 8'(empty), 8'd1);
    chk("rst_full", 8'(full), 8'd0);
    chk("rst_data", data_out, 8'h00);
    reset = 1'b0;

    // Packet write: header 0x29 (len 10, dest 1), 10 payload bytes, parity.
    addr = 2'b01; payload_len = 6'd10;
    parity = 8'h29;
    wr(8'h29, 1'b1, 1'b1);
    chk("hdr_empty", 8'(empty), 8'd0);
    for (int i = 0; i < 10; i++) begin
      wr(pay_a[i], 1'b0, 1'b1);
      parity = parity ^ pay_a[i];
    end
    wr(parity, 1'b0, 1'b1);
    write_enb = 1'b0;
    chk("pkt_full", 8'(full), 8'd0);

    // Packet read with a one-cycle pause mid-packet; data must hold while bytes remain.
    read_enb = 1'b1;
    repeat (5) @(negedge clock);
    read_enb = 1'b0;
    @(negedge clock);
    chk("hold_mid_pkt", data_out, pay_a[3]);
    read_enb = 1'b1;
    repeat (7) @(negedge clock);
    read_enb = 1'b0;
    chk("pkt_drained_empty", 8'(empty), 8'd1);
    @(negedge clock);
    chk("pkt_idle", data_out, 8'h00);

    // Full boundary: 17 writes, 17th dropped.
    for (int i = 0; i < 17; i++) begin
      wr(8'(8'h40 + i), 1'b0, (i < 16));
      if (i == 14) chk("full_at_15", 8'(full), 8'd0);
      if (i == 15) chk("full_at_16", 8'(full), 8'd1);
      if (i == 16) chk("full_after_drop", 8'(full), 8'd1);
    end
    write_enb = 1'b0;

    // Simultaneous read and write while full: read proceeds, write dropped.
    write_enb = 1'b1; data_in = 8'hEE; read_enb = 1'b1;
    chk("full_during_simul", 8'(full), 8'd1);
    @(negedge clock);
    write_enb = 1'b0;
    chk("simul_not_empty", 8'(empty), 8'd0);
    repeat (15) @(negedge clock);
    read_enb = 1'b0;
    chk("full_drained_empty", 8'(empty), 8'd1);
    @(negedge clock);

    // Soft reset after three reads of a 12-word packet.
    addr = 2'b10; payload_len = 6'd10;
    parity = 8'h29;
    wr(8'h29, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      wr(pay_b[i], 1'b0, 1'b1);
      parity = parity ^ pay_b[i];
    end
    wr(parity, 1'b0, 1'b1);
    write_enb = 1'b0;
    read_enb = 1'b1;
    repeat (3) @(negedge clock);
    read_enb = 1'b0;
    soft_reset = 1'b1;
    @(negedge clock);
    soft_reset = 1'b0;
    chk("srst_empty", 8'(empty), 8'd1);
    chk("srst_full", 8'(full), 8'd0);
    chk("srst_data_idle", data_out, 8'h00);
    exp_q.delete();

    // Fresh packet after flush: header 0x0E (len 3, dest 2).
    addr = 2'b10; payload_len = 6'd3;
    wr(8'h0E, 1'b1, 1'b1);
    wr(8'h11, 1'b0, 1'b1);
    wr(8'h22, 1'b0, 1'b1);
    wr(8'h33, 1'b0, 1'b1);
    wr(8'h0E ^ 8'h11 ^ 8'h22 ^ 8'h33, 1'b0, 1'b1);
    write_enb = 1'b0;
    read_enb = 1'b1;
    repeat (5) @(negedge clock);
    read_enb = 1'b0;
    chk("pkt2_empty", 8'(empty), 8'd1);
    @(negedge clock);
    chk("pkt2_idle", data_out, 8'h00);
    chk("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
